sdram_line_cache: RTL and testbench
===================================

SDRAM_LINE_CACHE -- requirements
Module: sdram_line_cache

Interface
REQ-001 Parameter: LINES, 128, number of direct-mapped lines (power of two; index width IDXW = log2(LINES)).
REQ-002 Ports: clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: bus_addr  in  24  CPU word address; bus_data  in  32  write data; bus_we  in  1  write enable; bus_start  in  1  request strobe.
REQ-005 Ports: bus_flush  in  1  invalidate all lines; bus_q  out  32  read data; bus_done  out  1  one-cycle completion pulse.
REQ-006 Ports: sdc_addr  out  24  controller address; sdc_data  out  32  controller write data; sdc_we  out  1  write enable; sdc_start  out  1  start trigger.
REQ-007 Ports: sdc_q  in  256  eight-word line from controller; sdc_ack  in  1  start accepted; sdc_busy  in  1  controller busy.

Function
REQ-008 Address split SHALL be: offset = bus_addr[2:0], index = bus_addr[3+IDXW-1:3], tag = remaining upper bits.
REQ-009 Line word w (offset w) SHALL map to sdc_q[255-32*w -: 32]; word 0 is most significant.
REQ-010 FSM states SHALL be IDLE, LOOKUP, FETCH_REQ, FETCH_WAIT, WRITE_REQ, WRITE_WAIT, DONE.
REQ-011 IDLE: bus_start high -> latch addr/data/we, issue data/tag RAM read, go LOOKUP; bus_start ignored in all other states.
REQ-012 LOOKUP: hit = valid[index] and stored tag equals tag.
REQ-013 Read hit: bus_q = cached word, bus_done pulses in DONE; bus_done SHALL be high exactly 2 cycles after the bus_start cycle.
REQ-014 Read miss: go FETCH_REQ with sdc_addr = {addr[23:3],3'b000}, sdc_we = 0.
REQ-015 Write (hit or miss): go WRITE_REQ with sdc_addr = latched addr, sdc_data = bus_data, sdc_we = 1; write hit also updates the cached word in the same cycle; write miss does not allocate.
REQ-016 *_REQ: sdc_start held high until the cycle sdc_ack is sampled high, then dropped and state moves to matching *_WAIT.
REQ-017 *_WAIT: completion is the first cycle sdc_busy is sampled low after ack; FETCH_WAIT then writes sdc_q into the line, writes tag, sets valid[index], and drives bus_q from the fetched line word at offset.
REQ-018 Completion of FETCH_WAIT/WRITE_WAIT SHALL go DONE; DONE pulses bus_done for one cycle and returns IDLE.
REQ-019 bus_q SHALL hold its value until the next read completion; writes do not change bus_q.
REQ-020 bus_flush in IDLE: clear all valid bits in one cycle; bus_flush asserted with bus_start: flush first, request still accepted and treated as a miss.
REQ-021 bus_flush outside IDLE SHALL be deferred (latched) and applied on the next IDLE cycle, after the in-flight line fill.
REQ-022 sdc_ack arriving while not in *_REQ SHALL be ignored.

Reset
REQ-023 Reset: state IDLE, all valid bits 0, pending flush 0; bus_q, bus_done, sdc_start, sdc_we, sdc_addr, sdc_data all 0.
REQ-024 Reset mid-transaction SHALL abandon it in one cycle: sdc_start low next cycle, no line/valid update, no bus_done.
REQ-025 Data/tag RAM contents are not reset; only valid bits are.

Structure
REQ-026 Shared package holds: state encoding, ADDR_W=24, WORD_W=32, LINE_W=256, WORDS_PER_LINE=8.
REQ-027 One sub-module: line_ram (simple dual-port synchronous RAM, LINES x (LINE_W+tag) bits, 1-cycle read latency) for inferred block RAM.

Verification
REQ-028 Read 0x000010 after reset, controller model returns line words 0x11..0x18 -> sdc_addr 0x000010, sdc_start until ack, bus_q = 0x11, bus_done once.
REQ-029 Read 0x000013 next -> no sdc_start, bus_q = 0x14, bus_done 2 cycles after bus_start.
REQ-030 Write 0xDEADBEEF to 0x000013 then read it -> one sdc write (we=1, addr 0x000013), read hits with bus_q = 0xDEADBEEF.
REQ-031 Read 0x000410 (same index, different tag for LINES=128) -> refill, then 0x000010 misses again.
REQ-032 bus_flush during FETCH_WAIT -> fill completes and bus_done pulses, then next read to that line misses.
REQ-033 reset asserted in FETCH_REQ with ack withheld -> sdc_start low next cycle, no bus_done, subsequent read of same address misses.

Source files
------------

// File: rtl/sdram_line_cache_pkg.sv
// Shared widths, FSM encoding and line word helpers for the SDRAM line cache.
// Word 0 of a line occupies the most significant 32 bits.
package sdram_line_cache_pkg;

  localparam int ADDR_W         = 24;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_WRITE_REQ,
    S_WRITE_WAIT,
    S_DONE
  } state_e;

  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] ln,
                                                 input logic [OFF_W-1:0]  off);
    return ln[LINE_W-1-WORD_W*int'(off) -: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] ln,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [WORD_W-1:0] w);
    logic [LINE_W-1:0] r;
    r = ln;
    r[LINE_W-1-WORD_W*int'(off) -: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/sdram_line_cache_line_ram.sv
// Simple dual-port synchronous RAM holding {tag, line} per cache index.
// One write port, one read port, registered read data (1-cycle latency).
module sdram_line_cache_line_ram #(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 270,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; line validity is tracked in flops.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sdram_line_cache.sv
// Direct-mapped, write-through, read-allocate line cache in front of an SDRAM
// controller that transfers whole 8-word lines on reads and single words on writes.
module sdram_line_cache
  import sdram_line_cache_pkg::*;
#(
  parameter int LINES = 128
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADDR_W-1:0]   bus_addr_i,
  input  logic [WORD_W-1:0]   bus_data_i,
  input  logic                bus_we_i,
  input  logic                bus_start_i,
  input  logic                bus_flush_i,
  output logic [WORD_W-1:0]   bus_q_o,
  output logic                bus_done_o,
  output logic [ADDR_W-1:0]   sdc_addr_o,
  output logic [WORD_W-1:0]   sdc_data_o,
  output logic                sdc_we_o,
  output logic                sdc_start_o,
  input  logic [LINE_W-1:0]   sdc_q_i,
  input  logic                sdc_ack_i,
  input  logic                sdc_busy_i
);

  localparam int IDXW  = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDXW;
  localparam int RAM_W = TAG_W + LINE_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   data_q;
  logic                we_q;
  logic [LINES-1:0]    valid_q;
  logic                flush_pend_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                done_q;
  logic [ADDR_W-1:0]   sdc_addr_q;
  logic [WORD_W-1:0]   sdc_data_q;
  logic                sdc_we_q;
  logic                sdc_start_q;

  logic [IDXW-1:0]     idx;
  logic [TAG_W-1:0]    tag;
  logic [OFF_W-1:0]    off;
  logic [RAM_W-1:0]    ram_rdata;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                hit;
  logic                ram_we;
  logic [RAM_W-1:0]    ram_wdata;

  assign idx  = addr_q[OFF_W +: IDXW];
  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign off  = addr_q[OFF_W-1:0];
  assign {rd_tag, rd_line} = ram_rdata;
  assign hit  = valid_q[idx] && (rd_tag == tag);

  // The read is issued from the live bus address so the lookup data is ready in LOOKUP.
  sdram_line_cache_line_ram #(
    .DEPTH (LINES),
    .WIDTH (RAM_W)
  ) u_line_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (idx),
    .wdata_i (ram_wdata),
    .raddr_i (bus_addr_i[OFF_W +: IDXW]),
    .rdata_o (ram_rdata)
  );

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = {tag, rd_line};
    if (!reset_i) begin
      unique case (state_q)
        S_LOOKUP: if (we_q && hit) begin
          ram_we    = 1'b1;
          ram_wdata = {tag, put_word(rd_line, off, data_q)};
        end
        S_FETCH_WAIT: if (!sdc_busy_i) begin
          ram_we    = 1'b1;
          ram_wdata = {tag, sdc_q_i};
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      sdc_addr_q   <= '0;
      sdc_data_q   <= '0;
      sdc_we_q     <= 1'b0;
      sdc_start_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // Flush is applied before a same-cycle request, which therefore misses.
          if (bus_flush_i || flush_pend_q) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end
          if (bus_start_i) begin
            addr_q  <= bus_addr_i;
            data_q  <= bus_data_i;
            we_q    <= bus_we_i;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (we_q) begin
            sdc_addr_q  <= addr_q;
            sdc_data_q  <= data_q;
            sdc_we_q    <= 1'b1;
            sdc_start_q <= 1'b1;
            state_q     <= S_WRITE_REQ;
          end else if (hit) begin
            rdata_q <= get_word(rd_line, off);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sdc_addr_q  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b1;
            state_q     <= S_FETCH_REQ;
          end
        end
        S_FETCH_REQ, S_WRITE_REQ: begin
          if (sdc_ack_i) begin
            sdc_start_q <= 1'b0;
            state_q     <= (state_q == S_FETCH_REQ) ? S_FETCH_WAIT : S_WRITE_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          if (!sdc_busy_i) begin
            valid_q[idx] <= 1'b1;
            rdata_q      <= get_word(sdc_q_i, off);
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_WRITE_WAIT: begin
          if (!sdc_busy_i) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (bus_flush_i && (state_q != S_IDLE)) flush_pend_q <= 1'b1;
    end
  end

  assign bus_q_o     = rdata_q;
  assign bus_done_o  = done_q;
  assign sdc_addr_o  = sdc_addr_q;
  assign sdc_data_o  = sdc_data_q;
  assign sdc_we_o    = sdc_we_q;
  assign sdc_start_o = sdc_start_q;

endmodule

// File: tb/tb_sdram_line_cache.sv
// Directed bench for sdram_line_cache: a controller model answers requests,
// a scoreboard queue holds the expected bus_q for every bus_done pulse.
module tb_sdram_line_cache;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [23:0]   bus_addr_i = '0;
  logic [31:0]   bus_data_i = '0;
  logic          bus_we_i = 1'b0;
  logic          bus_start_i = 1'b0;
  logic          bus_flush_i = 1'b0;
  logic [31:0]   bus_q_o;
  logic          bus_done_o;
  logic [23:0]   sdc_addr_o;
  logic [31:0]   sdc_data_o;
  logic          sdc_we_o;
  logic          sdc_start_o;
  logic [255:0]  sdc_q_i = '0;
  logic          sdc_ack_i = 1'b0;
  logic          sdc_busy_i = 1'b0;

  sdram_line_cache #(.LINES(128)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .bus_addr_i  (bus_addr_i),
    .bus_data_i  (bus_data_i),
    .bus_we_i    (bus_we_i),
    .bus_start_i (bus_start_i),
    .bus_flush_i (bus_flush_i),
    .bus_q_o     (bus_q_o),
    .bus_done_o  (bus_done_o),
    .sdc_addr_o  (sdc_addr_o),
    .sdc_data_o  (sdc_data_o),
    .sdc_we_o    (sdc_we_o),
    .sdc_start_o (sdc_start_o),
    .sdc_q_i     (sdc_q_i),
    .sdc_ack_i   (sdc_ack_i),
    .sdc_busy_i  (sdc_busy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [31:0] data;
  } req_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] sb_q [$];
  req_t        req_log [$];
  logic [31:0] last_q = '0;
  logic [255:0] fill_line = '0;
  bit          ctrl_en = 1'b1;
  int          ack_lat = 2;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[255-32*w -: 32] = base + 32'(w);
    return l;
  endfunction

  // Controller model: acks after ack_lat cycles of sdc_start, stays busy 4 cycles.
  typedef enum {M_IDLE, M_BUSY} m_e;
  m_e   m_st = M_IDLE;
  int   m_cnt = 0;
  logic m_we = 1'b0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      sdc_ack_i  = 1'b0;
      sdc_busy_i = 1'b0;
      m_st       = M_IDLE;
      m_cnt      = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          sdc_ack_i = 1'b0;
          if (sdc_start_o && ctrl_en) begin
            if (m_cnt >= ack_lat) begin
              sdc_ack_i  = 1'b1;
              sdc_busy_i = 1'b1;
              m_we       = sdc_we_o;
              req_log.push_back('{sdc_addr_o, sdc_we_o, sdc_data_o});
              m_st       = M_BUSY;
              m_cnt      = 3;
            end else m_cnt++;
          end else m_cnt = 0;
        end
        default: begin
          sdc_ack_i = 1'b0;
          if (m_cnt == 0) begin
            sdc_busy_i = 1'b0;
            if (!m_we) sdc_q_i = fill_line;
            m_st = M_IDLE;
          end else m_cnt--;
        end
      endcase
    end
  end

  // Monitor: every bus_done pulse consumes one scoreboard entry.
  always @(negedge clk_i) begin
    if (bus_done_o) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb_q.size() == 0) check("unexpected_done", 64'(bus_q_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("bus_q", 64'(bus_q_o), 64'(sb_q.pop_front()));
    end
  end

  task automatic wait_done(input int n_done, input bit flush_mid);
    bit armed = flush_mid;
    bit fl_now = 1'b0;
    for (int i = 0; i < 100 && done_cnt == n_done; i++) begin
      bus_flush_i = 1'b0;
      if (fl_now) begin
        bus_flush_i = 1'b1;
        fl_now = 1'b0;
      end
      if (armed && sdc_ack_i) begin
        fl_now = 1'b1;
        armed  = 1'b0;
      end
      @(negedge clk_i); #1;
    end
    bus_flush_i = 1'b0;
    check("done_count", 64'(done_cnt - n_done), 64'd1);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [255:0] fill, input logic [31:0] exp,
                         input bit exp_miss, input bit flush_mid, input bit flush_start);
    int n_log, n_done, c0;
    sb_q.push_back(exp);
    last_q    = exp;
    fill_line = fill;
    n_log  = req_log.size();
    n_done = done_cnt;
    @(negedge clk_i); #1;
    bus_addr_i  = a;
    bus_we_i    = 1'b0;
    bus_start_i = 1'b1;
    bus_flush_i = flush_start;
    c0 = cyc;
    @(negedge clk_i); #1;
    bus_start_i = 1'b0;
    bus_flush_i = 1'b0;
    wait_done(n_done, flush_mid);
    check("sdc_req_count", 64'(req_log.size() - n_log), 64'(exp_miss));
    if (exp_miss && req_log.size() > n_log) begin
      check("fetch_addr", 64'(req_log[req_log.size()-1].addr), 64'({a[23:3], 3'b000}));
      check("fetch_we", 64'(req_log[req_log.size()-1].we), 64'd0);
    end
    if (!exp_miss) check("hit_latency", 64'(done_cyc - c0), 64'd2);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [31:0] d);
    int n_log, n_done;
    sb_q.push_back(last_q);
    n_log  = req_log.size();
    n_done = done_cnt;
    @(negedge clk_i); #1;
    bus_addr_i  = a;
    bus_data_i  = d;
    bus_we_i    = 1'b1;
    bus_start_i = 1'b1;
    @(negedge clk_i); #1;
    bus_start_i = 1'b0;
    bus_we_i    = 1'b0;
    wait_done(n_done, 1'b0);
    check("sdc_wr_count", 64'(req_log.size() - n_log), 64'd1);
    if (req_log.size() > n_log) begin
      check("wr_addr", 64'(req_log[req_log.size()-1].addr), 64'(a));
      check("wr_we", 64'(req_log[req_log.size()-1].we), 64'd1);
      check("wr_data", 64'(req_log[req_log.size()-1].data), 64'(d));
    end
  endtask

  initial begin
    int n_done;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_bus_q", 64'(bus_q_o), 64'd0);
    check("rst_bus_done", 64'(bus_done_o), 64'd0);
    check("rst_sdc_start", 64'(sdc_start_o), 64'd0);
    check("rst_sdc_we", 64'(sdc_we_o), 64'd0);
    check("rst_sdc_addr", 64'(sdc_addr_o), 64'd0);
    check("rst_sdc_data", 64'(sdc_data_o), 64'd0);
    reset_i = 1'b0;

    do_read(24'h000010, mk_line(32'h11), 32'h11, 1'b1, 1'b0, 1'b0);
    do_read(24'h000013, '0, 32'h14, 1'b0, 1'b0, 1'b0);
    do_write(24'h000013, 32'hDEADBEEF);
    do_read(24'h000013, '0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    do_read(24'h000410, mk_line(32'h21), 32'h21, 1'b1, 1'b0, 1'b0);
    do_read(24'h000010, mk_line(32'h41), 32'h41, 1'b1, 1'b0, 1'b0);
    do_read(24'h000017, '0, 32'h48, 1'b0, 1'b0, 1'b0);
    do_write(24'h000800, 32'hCAFEF00D);
    do_read(24'h000800, mk_line(32'h81), 32'h81, 1'b1, 1'b0, 1'b0);
    do_read(24'h000020, mk_line(32'h51), 32'h51, 1'b1, 1'b1, 1'b0);
    do_read(24'h000020, mk_line(32'h61), 32'h61, 1'b1, 1'b0, 1'b0);
    do_read(24'h000021, mk_line(32'h61), 32'h62, 1'b1, 1'b0, 1'b1);
    do_read(24'h000022, '0, 32'h63, 1'b0, 1'b0, 1'b0);

    // Reset while a fetch request is waiting for an ack that never comes.
    ctrl_en = 1'b0;
    n_done  = done_cnt;
    @(negedge clk_i); #1;
    bus_addr_i  = 24'h000030;
    bus_start_i = 1'b1;
    @(negedge clk_i); #1;
    bus_start_i = 1'b0;
    for (int i = 0; i < 20 && !sdc_start_o; i++) begin
      @(negedge clk_i); #1;
    end
    check("start_before_reset", 64'(sdc_start_o), 64'd1);
    reset_i = 1'b1;
    @(negedge clk_i); #1;
    check("start_after_reset", 64'(sdc_start_o), 64'd0);
    reset_i = 1'b0;
    ctrl_en = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    check("no_done_after_reset", 64'(done_cnt - n_done), 64'd0);
    check("bus_q_after_reset", 64'(bus_q_o), 64'd0);
    do_read(24'h000030, mk_line(32'h71), 32'h71, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
